// File: rtl/cnt_multi.sv
// N-channel base/addr/cnt address generator with a per-instance wrap policy.
// Each channel loads base/addr from inp and steps addr by STRIDE for LIMIT steps per period.
module cnt_multi #(
  parameter int W      = 16,
  parameter int N      = 4,
  parameter int CW     = 2,
  parameter int STRIDE = 1,
  parameter int LIMIT  = 4,
  parameter int MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     inp,
  input  logic             en,
  input  logic [CW-1:0]    ch_sel,
  input  logic [N-1:0]     adv,
  output logic [N*W-1:0]   base,
  output logic [N*W-1:0]   addr,
  output logic [N*W-1:0]   cnt,
  output logic [N-1:0]     done,
  output logic [N-1:0]     wrapped
);

  localparam bit         IS_WRAP    = (MODE == 1);
  localparam bit         IS_STOP    = (MODE == 2);
  localparam logic [W-1:0] STRIDE_W   = W'(STRIDE);
  localparam logic [W-1:0] LIMIT_W    = W'(LIMIT);
  localparam logic [W-1:0] LIMIT_M1   = W'(LIMIT - 1);
  localparam logic [W-1:0] LIM_STRIDE = W'(LIMIT * STRIDE);
  localparam logic [W-1:0] HALF       = W'(1) << (W - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] base_q;
    logic [W-1:0] addr_q;
    logic [W-1:0] cnt_q;
    logic         done_q;
    logic         wrap_q;
    logic         load;

    // ch_sel values at or above N match no channel, so such loads fall through.
    assign load = en && (ch_sel == CW'(i));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        base_q <= '0;
        addr_q <= '0;
        cnt_q  <= '0;
        done_q <= 1'b0;
        wrap_q <= 1'b0;
      end else if (load) begin
        base_q <= inp;
        addr_q <= inp;
        cnt_q  <= '0;
        done_q <= 1'b0;
        wrap_q <= 1'b0;
      end else if (adv[i] && !done_q) begin
        if (cnt_q == LIMIT_M1) begin
          wrap_q <= 1'b1;
          if (IS_WRAP) begin
            addr_q <= base_q;
            cnt_q  <= '0;
          end else if (IS_STOP) begin
            addr_q <= addr_q + STRIDE_W;
            done_q <= 1'b1;
          end else begin
            addr_q <= addr_q + STRIDE_W;
            cnt_q  <= '0;
          end
        end else begin
          addr_q <= addr_q + STRIDE_W;
          cnt_q  <= cnt_q + W'(1);
          wrap_q <= 1'b0;
        end
      end else begin
        wrap_q <= 1'b0;
      end
    end

    assign base[i*W +: W] = base_q;
    assign addr[i*W +: W] = addr_q;
    assign cnt[i*W +: W]  = cnt_q;
    assign done[i]        = done_q;
    assign wrapped[i]     = wrap_q;

    a_cnt_lt_limit: assert property (@(posedge clk) disable iff (!rst_n)
      cnt_q < LIMIT_W);

    // A halted STOP channel has taken its terminal step, so addr sits one stride past the last count.
    a_addr_track: assert property (@(posedge clk) disable iff (!rst_n)
      !(IS_WRAP || IS_STOP) ||
      (done_q ? (addr_q == base_q + LIM_STRIDE)
              : (addr_q == base_q + cnt_q * STRIDE_W)));

    a_done_stop_only: assert property (@(posedge clk) disable iff (!rst_n)
      IS_STOP || !done_q);

    c_half_base: cover property (@(posedge clk)
      rst_n && base_q == HALF && addr_q == base_q + STRIDE_W && cnt_q == W'(1));
  end

endmodule

// File: tb/tb_cnt_multi.sv
// Directed bench for cnt_multi: WRAP, STOP and FREE instances driven from shared stimulus.
module tb_cnt_multi;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  ch_sel;
  logic [3:0]  adv;
  logic [15:0] inp;
  logic [3:0]  inp4;

  logic [63:0] w_base, w_addr, w_cnt;
  logic [3:0]  w_done, w_wrap;
  logic [63:0] s_base, s_addr, s_cnt;
  logic [3:0]  s_done, s_wrap;
  logic [11:0] f_base, f_addr, f_cnt;
  logic [2:0]  f_done, f_wrap;

  int n_chk;
  int n_bad;

  cnt_multi #(.W(16), .N(4), .CW(2), .STRIDE(1), .LIMIT(4), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .inp(inp), .en(en), .ch_sel(ch_sel), .adv(adv),
    .base(w_base), .addr(w_addr), .cnt(w_cnt), .done(w_done), .wrapped(w_wrap));

  cnt_multi #(.W(16), .N(4), .CW(2), .STRIDE(1), .LIMIT(4), .MODE(2)) dut_stop (
    .clk(clk), .rst_n(rst_n), .inp(inp), .en(en), .ch_sel(ch_sel), .adv(adv),
    .base(s_base), .addr(s_addr), .cnt(s_cnt), .done(s_done), .wrapped(s_wrap));

  cnt_multi #(.W(4), .N(3), .CW(2), .STRIDE(3), .LIMIT(4), .MODE(0)) dut_free (
    .clk(clk), .rst_n(rst_n), .inp(inp4), .en(en), .ch_sel(ch_sel), .adv(adv[2:0]),
    .base(f_base), .addr(f_addr), .cnt(f_cnt), .done(f_done), .wrapped(f_wrap));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;

    // T1: reset dominates load and advance
    rst_n = 1'b0; en = 1'b1; ch_sel = 2'd0; adv = 4'hF; inp = 16'hFFFF; inp4 = 4'hF;
    step();
    chk("t1_base", w_base, 64'h0);
    chk("t1_addr", w_addr, 64'h0);
    chk("t1_cnt", w_cnt, 64'h0);
    chk("t1_done", {60'h0, s_done}, 64'h0);
    chk("t1_wrap", {60'h0, w_wrap}, 64'h0);
    rst_n = 1'b1; en = 1'b0; adv = 4'h0;

    // T2: load ch2 with 8000, one advance
    en = 1'b1; ch_sel = 2'd2; inp = 16'h8000;
    step();
    chk("t2_load_addr", w_addr, 64'h8000_0000_0000);
    en = 1'b0; adv = 4'b0100;
    step();
    adv = 4'h0;
    chk("t2_base", w_base, 64'h0000_8000_0000_0000);
    chk("t2_addr", w_addr, 64'h0000_8001_0000_0000);
    chk("t2_cnt", w_cnt, 64'h0000_0001_0000_0000);
    chk("t2_wrap", {60'h0, w_wrap}, 64'h0);

    // T3: WRAP, ch0 loaded with 10, four advances
    en = 1'b1; ch_sel = 2'd0; inp = 16'd10;
    step();
    en = 1'b0; adv = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t3_addr_%0d", k), w_addr[15:0], (k < 4) ? 64'(10 + k) : 64'd10);
      chk($sformatf("t3_cnt_%0d", k), w_cnt[15:0], 64'(k % 4));
      chk($sformatf("t3_wrap_%0d", k), w_wrap[0], (k == 4) ? 64'd1 : 64'd0);
    end
    adv = 4'h0;
    step();
    chk("t3_wrap_drop", w_wrap[0], 64'd0);

    // T4: STOP, ch1 loaded with 5, six advances, then reload 0
    en = 1'b1; ch_sel = 2'd1; inp = 16'd5;
    step();
    en = 1'b0; adv = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t4_addr_%0d", k), s_addr[31:16], (k < 4) ? 64'(5 + k) : 64'd9);
      chk($sformatf("t4_cnt_%0d", k), s_cnt[31:16], (k < 3) ? 64'(k) : 64'd3);
      chk($sformatf("t4_done_%0d", k), s_done[1], (k >= 4) ? 64'd1 : 64'd0);
      chk($sformatf("t4_wrap_%0d", k), s_wrap[1], (k == 4) ? 64'd1 : 64'd0);
    end
    en = 1'b1; ch_sel = 2'd1; inp = 16'd0; adv = 4'h0;
    step();
    en = 1'b0;
    chk("t4_reload_done", s_done[1], 64'd0);
    chk("t4_reload_addr", s_addr[31:16], 64'd0);
    chk("t4_reload_cnt", s_cnt[31:16], 64'd0);

    // T5: load and advance together on ch3 at cnt=2; load wins
    en = 1'b1; ch_sel = 2'd3; inp = 16'h0020;
    step();
    en = 1'b0; adv = 4'b1000;
    step();
    step();
    chk("t5_pre_cnt", w_cnt[63:48], 64'd2);
    chk("t5_pre_addr", w_addr[63:48], 64'h22);
    en = 1'b1; ch_sel = 2'd3; inp = 16'd7; adv = 4'b1000;
    step();
    en = 1'b0; adv = 4'h0;
    chk("t5_addr", w_addr[63:48], 64'd7);
    chk("t5_base", w_base[63:48], 64'd7);
    chk("t5_cnt", w_cnt[63:48], 64'd0);

    // mid-run reset with live state clears everything
    rst_n = 1'b0; en = 1'b1; ch_sel = 2'd2; adv = 4'hF; inp = 16'h1234;
    step();
    rst_n = 1'b1; en = 1'b0; adv = 4'h0;
    chk("rst2_base", w_base, 64'h0);
    chk("rst2_addr", w_addr, 64'h0);
    chk("rst2_cnt", w_cnt, 64'h0);
    chk("rst2_sbase", s_base, 64'h0);
    chk("rst2_fbase", {52'h0, f_base}, 64'h0);

    // T6: FREE, W=4 STRIDE=3, ch0 loaded with 14, four advances wrap mod 16
    en = 1'b1; ch_sel = 2'd0; inp4 = 4'd14; inp = 16'd0;
    step();
    en = 1'b0; adv = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_addr_%0d", k), f_addr[3:0], 64'((14 + 3 * k) % 16));
      chk($sformatf("t6_cnt_%0d", k), f_cnt[3:0], 64'(k % 4));
      chk($sformatf("t6_wrap_%0d", k), f_wrap[0], (k == 4) ? 64'd1 : 64'd0);
    end
    adv = 4'h0;
    chk("t6_done", {61'h0, f_done}, 64'h0);

    // load to a channel index beyond N on the 3-channel instance is ignored
    en = 1'b1; ch_sel = 2'd3; inp4 = 4'd9;
    step();
    en = 1'b0;
    chk("oob_base", {52'h0, f_base}, 64'h00E);
    chk("oob_addr", {52'h0, f_addr}, 64'h00A);
    chk("oob_cnt", {52'h0, f_cnt}, 64'h000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
